hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter XLEN, 32, instruction/address width.
REQ-002 Parameter REG_AW, 5, register index width.
REQ-003 Parameter LOAD_STALL, 1, total stall cycles per load-use hazard, legal 1..4.
REQ-004 Parameter MULDIV_LAT, 4, total hold cycles per multi-cycle EX op, legal 1..16.
REQ-005 Parameter BR_FLUSH, 1, IF/ID flush cycles per taken branch, legal 1..2.
REQ-006 clk_i  in  1  sole clock, all state on rising edge.
REQ-007 rst_i  in  1  reset, asynchronous, active-low.
REQ-008 MemtoReg_i  in  1  EX-stage instruction is a load.
REQ-009 RD_i  in  REG_AW  EX-stage destination register.
REQ-010 instr_i  in  XLEN  ID-stage instruction.
REQ-011 addr_i  in  XLEN  ID-stage PC.
REQ-012 Branch_i  in  1  taken branch resolved in ID.
REQ-013 MulDiv_i  in  1  EX-stage instruction is multi-cycle mul/div.
REQ-014 MemBusy_i  in  1  data memory not ready.
REQ-015 Stall_o  out  1  hold PC and IF/ID.
REQ-016 Bubble_o  out  1  insert NOP into ID/EX.
REQ-017 Hold_o  out  1  freeze ID/EX and EX/MEM.
REQ-018 Flush_o  out  1  zero IF/ID.
REQ-019 instr_o, addr_o  out  XLEN  combinational pass-through of instr_i, addr_i.
REQ-020 State_o  out  2  FSM state: IDLE=0, LOAD_WAIT=1, MULDIV=2.

Function
REQ-021 Load-use hit SHALL be MemtoReg_i && RD_i!=0 && (instr_i[19:15]==RD_i || (instr_i[5] && instr_i[24:20]==RD_i)).
REQ-022 In IDLE, a hit SHALL assert Stall_o and Bubble_o combinationally in the same cycle; if LOAD_STALL>1, FSM enters LOAD_WAIT with down-counter = LOAD_STALL-1.
REQ-023 In LOAD_WAIT, Stall_o and Bubble_o SHALL stay asserted, counter decrements each unfrozen cycle, and the FSM returns to IDLE on the edge where the counter reaches 0; total = exactly LOAD_STALL cycles; hit input ignored.
REQ-024 In IDLE, MulDiv_i=1 SHALL assert Stall_o and Hold_o the same cycle; if MULDIV_LAT>1, FSM enters MULDIV with counter = MULDIV_LAT-1, holding until the counter reaches 0; total = exactly MULDIV_LAT cycles; Bubble_o=0.
REQ-025 MulDiv_i and a hit in the same IDLE cycle SHALL resolve to MulDiv (illegal combination, deterministic result).
REQ-026 MemBusy_i=1 SHALL assert Stall_o and Hold_o combinationally in every state, force Bubble_o=0, and freeze the counter and FSM state.
REQ-027 Flush_o SHALL equal Branch_i && !Stall_o; a stalled branch is not flushed until Stall_o drops.
REQ-028 With BR_FLUSH=2, issuing Flush_o SHALL set a pending bit; Flush_o is also asserted on the next cycle with Stall_o=0, clearing the pending bit; with BR_FLUSH=1 the pending bit is never set.
REQ-029 Priority SHALL be MemBusy > MULDIV > LOAD_WAIT/hit > flush.
REQ-030 Counter width SHALL be $clog2(16)+1 bits; no wrap-around is possible within legal parameters.

Reset
REQ-031 rst_i=0 SHALL immediately force state IDLE, counter 0, and pending-flush 0, aborting any LOAD_WAIT/MULDIV in progress.
REQ-032 After reset, with all inputs 0, Stall_o, Bubble_o, Hold_o, Flush_o SHALL be 0 and State_o=0.

Verification
REQ-033 LOAD_STALL=3, MemtoReg_i=1, RD_i=5, instr_i rs1=5 for one cycle -> Stall_o=Bubble_o=1 for exactly 3 cycles, then State_o=0.
REQ-034 RD_i=0 hit, or rs2 match with instr_i[5]=0 -> no stall.
REQ-035 MULDIV_LAT=4, MulDiv_i pulse, MemBusy_i=1 on 2nd cycle for 2 cycles -> Stall_o=Hold_o=1 for 6 cycles total.
REQ-036 BR_FLUSH=2, Branch_i=1 one cycle, Stall_o=0 -> Flush_o=1 on 2 consecutive cycles; with a hit coincident with Branch_i -> Flush_o=0 until stall ends.
REQ-037 rst_i low during MULDIV cycle 2 -> State_o=0, Hold_o=0 immediately, no residual hold after release.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, multi-cycle EX holds, memory-busy freeze
// and taken-branch IF/ID flushes, with ID-stage instruction/PC passed straight through.
module hazard_ctrl #(
  parameter int XLEN       = 32,
  parameter int REG_AW     = 5,
  parameter int LOAD_STALL = 1,
  parameter int MULDIV_LAT = 4,
  parameter int BR_FLUSH   = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemtoReg_i,
  input  logic [REG_AW-1:0] RD_i,
  input  logic [XLEN-1:0]   instr_i,
  input  logic [XLEN-1:0]   addr_i,
  input  logic              Branch_i,
  input  logic              MulDiv_i,
  input  logic              MemBusy_i,
  output logic              Stall_o,
  output logic              Bubble_o,
  output logic              Hold_o,
  output logic              Flush_o,
  output logic [XLEN-1:0]   instr_o,
  output logic [XLEN-1:0]   addr_o,
  output logic [1:0]        State_o
);

  localparam int CW = $clog2(16) + 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    MULDIV    = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pend_q, pend_d;
  logic [REG_AW-1:0] rs1, rs2;
  logic            hit;
  logic            stall, bubble, hold, flush;

  assign rs1 = instr_i[15 +: REG_AW];
  assign rs2 = instr_i[20 +: REG_AW];
  assign hit = MemtoReg_i && (RD_i != '0) &&
               ((rs1 == RD_i) || (instr_i[5] && (rs2 == RD_i)));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    bubble  = 1'b0;
    hold    = 1'b0;
    if (MemBusy_i) begin
      // Memory not ready freezes everything, including the wait counter.
      stall = 1'b1;
      hold  = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (MulDiv_i) begin
            stall = 1'b1;
            hold  = 1'b1;
            if (MULDIV_LAT > 1) begin
              state_d = MULDIV;
              cnt_d   = CW'(MULDIV_LAT - 1);
            end
          end else if (hit) begin
            stall  = 1'b1;
            bubble = 1'b1;
            if (LOAD_STALL > 1) begin
              state_d = LOAD_WAIT;
              cnt_d   = CW'(LOAD_STALL - 1);
            end
          end
        end
        LOAD_WAIT: begin
          stall  = 1'b1;
          bubble = 1'b1;
          cnt_d  = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = IDLE;
        end
        MULDIV: begin
          stall = 1'b1;
          hold  = 1'b1;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // A second flush cycle is owed only for two-cycle flushes; it waits out any stall.
  always_comb begin
    flush  = (Branch_i || pend_q) && !stall;
    pend_d = pend_q;
    if (flush) pend_d = (BR_FLUSH == 2) && !pend_q;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  assign Stall_o  = stall;
  assign Bubble_o = bubble;
  assign Hold_o   = hold;
  assign Flush_o  = flush;
  assign State_o  = state_q;
  assign instr_o  = instr_i;
  assign addr_o   = addr_i;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two parameterisations driven in lockstep, checked every cycle
// against a remaining-cycles reference model, plus directed scenarios and random traffic.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, memtoreg, branch, muldiv, membusy;
  logic [4:0]  rd;
  logic [31:0] instr, addr;

  logic        stall_a, bubble_a, hold_a, flush_a;
  logic        stall_b, bubble_b, hold_b, flush_b;
  logic [31:0] instr_oa, addr_oa, instr_ob, addr_ob;
  logic [1:0]  state_a, state_b;

  hazard_ctrl #(.XLEN(32), .REG_AW(5), .LOAD_STALL(3), .MULDIV_LAT(4), .BR_FLUSH(2)) u_a (
    .clk_i(clk), .rst_i(rst_n), .MemtoReg_i(memtoreg), .RD_i(rd), .instr_i(instr),
    .addr_i(addr), .Branch_i(branch), .MulDiv_i(muldiv), .MemBusy_i(membusy),
    .Stall_o(stall_a), .Bubble_o(bubble_a), .Hold_o(hold_a), .Flush_o(flush_a),
    .instr_o(instr_oa), .addr_o(addr_oa), .State_o(state_a));

  hazard_ctrl #(.XLEN(32), .REG_AW(5), .LOAD_STALL(1), .MULDIV_LAT(1), .BR_FLUSH(1)) u_b (
    .clk_i(clk), .rst_i(rst_n), .MemtoReg_i(memtoreg), .RD_i(rd), .instr_i(instr),
    .addr_i(addr), .Branch_i(branch), .MulDiv_i(muldiv), .MemBusy_i(membusy),
    .Stall_o(stall_b), .Bubble_o(bubble_b), .Hold_o(hold_b), .Flush_o(flush_b),
    .instr_o(instr_ob), .addr_o(addr_ob), .State_o(state_b));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model: kind = what is holding the pipe (0 none, 1 load, 2 mul/div),
  // rem = cycles still owed after the current one, fl = owed extra flush cycles.
  int p_ls[2] = '{3, 1};
  int p_md[2] = '{4, 1};
  int p_bf[2] = '{2, 1};
  int kind[2], rem[2], fl[2];
  int cnt_stall_a, cnt_hold_a, cnt_flush_a, cnt_flush_b;

  function automatic bit load_use();
    logic [4:0] r1, r2;
    r1 = instr[19:15];
    r2 = instr[24:20];
    return memtoreg && (rd != 0) && (r1 == rd || (instr[5] && r2 == rd));
  endfunction

  task automatic eval_and_check();
    bit e_st, e_bu, e_ho, e_fl;
    logic [5:0] obs, exp;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        kind[i] = 0; rem[i] = 0; fl[i] = 0;
      end
      e_st = 0; e_bu = 0; e_ho = 0;
      if (membusy) begin
        e_st = 1; e_ho = 1;
      end else if (kind[i] != 0) begin
        e_st = 1; e_bu = (kind[i] == 1); e_ho = (kind[i] == 2);
      end else if (muldiv) begin
        e_st = 1; e_ho = 1;
      end else if (load_use()) begin
        e_st = 1; e_bu = 1;
      end
      e_fl = !e_st && (branch || fl[i] > 0);
      exp = {e_st, e_bu, e_ho, e_fl, 2'(kind[i])};
      if (i == 0) obs = {stall_a, bubble_a, hold_a, flush_a, state_a};
      else        obs = {stall_b, bubble_b, hold_b, flush_b, state_b};
      check(i == 0 ? "ctl_a" : "ctl_b", 32'(obs), 32'(exp));
      if (rst_n) begin
        if (!membusy) begin
          if (kind[i] != 0) begin
            rem[i]--;
            if (rem[i] == 0) kind[i] = 0;
          end else if (muldiv) begin
            if (p_md[i] > 1) begin kind[i] = 2; rem[i] = p_md[i] - 1; end
          end else if (load_use()) begin
            if (p_ls[i] > 1) begin kind[i] = 1; rem[i] = p_ls[i] - 1; end
          end
        end
        if (e_fl) fl[i] = (fl[i] > 0) ? 0 : p_bf[i] - 1;
      end
    end
    check("instr_pass", instr_oa, instr);
    check("addr_pass", addr_ob, addr);
    cnt_stall_a += int'(stall_a);
    cnt_hold_a  += int'(hold_a);
    cnt_flush_a += int'(flush_a);
    cnt_flush_b += int'(flush_b);
  endtask

  task automatic cycle();
    @(negedge clk);
    eval_and_check();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    memtoreg = 0; rd = 0; instr = 0; branch = 0; muldiv = 0; membusy = 0;
  endtask

  task automatic clear_counts();
    cnt_stall_a = 0; cnt_hold_a = 0; cnt_flush_a = 0; cnt_flush_b = 0;
  endtask

  initial begin
    rst_n = 0; addr = 32'h1000;
    idle_inputs();
    for (int i = 0; i < 2; i++) begin kind[i] = 0; rem[i] = 0; fl[i] = 0; end
    clear_counts();
    #1;
    cycle();
    check("rst_state_a", 32'(state_a), 0);
    rst_n = 1;
    cycle();
    check("idle_out_a", 32'({stall_a, bubble_a, hold_a, flush_a}), 0);

    // Load-use on rs1 for one cycle: three stall cycles on u_a, one on u_b.
    clear_counts();
    memtoreg = 1; rd = 5; instr = 32'd5 << 15;
    cycle();
    idle_inputs();
    for (int k = 0; k < 5; k++) cycle();
    check("load_stall_len", cnt_stall_a, 3);
    check("load_end_state", 32'(state_a), 0);

    // RD=0 match and rs2 match without bit 5: no stall either way.
    clear_counts();
    memtoreg = 1; rd = 0; instr = 32'd0;
    cycle();
    rd = 7; instr = 32'd7 << 20;
    cycle();
    instr = (32'd7 << 20) | 32'h20;
    cycle();
    idle_inputs();
    for (int k = 0; k < 4; k++) cycle();
    check("rs2_only_stall", cnt_stall_a, 3);

    // Mul/div pulse with memory busy in its 2nd and 3rd cycles: six held cycles.
    clear_counts();
    muldiv = 1;
    cycle();
    muldiv = 0; membusy = 1;
    cycle();
    cycle();
    membusy = 0;
    for (int k = 0; k < 6; k++) cycle();
    check("muldiv_busy_len", cnt_hold_a, 6);

    // Lone branch: two flushes on u_a, one on u_b.
    clear_counts();
    branch = 1;
    cycle();
    branch = 0;
    for (int k = 0; k < 3; k++) cycle();
    check("flush2_count", cnt_flush_a, 2);
    check("flush1_count", cnt_flush_b, 1);

    // Branch coinciding with a load-use hit, held until the stall clears.
    clear_counts();
    branch = 1; memtoreg = 1; rd = 9; instr = 32'd9 << 15;
    cycle();
    memtoreg = 0; rd = 0; instr = 0;
    cycle();
    cycle();
    check("flush_held_off", cnt_flush_a, 0);
    cycle();
    branch = 0;
    for (int k = 0; k < 3; k++) cycle();
    check("flush_after_stall", cnt_flush_a, 2);

    // Reset during the second mul/div cycle aborts the hold with nothing left behind.
    clear_counts();
    muldiv = 1;
    cycle();
    muldiv = 0;
    cycle();
    rst_n = 0;
    #1;
    check("rst_abort_hold", 32'(hold_a), 0);
    check("rst_abort_state", 32'(state_a), 0);
    cycle();
    rst_n = 1;
    clear_counts();
    for (int k = 0; k < 4; k++) cycle();
    check("no_residual_hold", cnt_hold_a, 0);

    // Random traffic with small register indices to make hazards frequent.
    for (int k = 0; k < 3000; k++) begin
      memtoreg = ($urandom_range(0, 99) < 45);
      rd       = 5'($urandom_range(0, 3));
      instr    = $urandom;
      instr[19:15] = 5'($urandom_range(0, 3));
      instr[24:20] = 5'($urandom_range(0, 3));
      addr     = $urandom;
      branch   = ($urandom_range(0, 99) < 20);
      muldiv   = ($urandom_range(0, 99) < 10);
      membusy  = ($urandom_range(0, 99) < 15);
      rst_n    = ($urandom_range(0, 99) >= 2);
      cycle();
    end
    rst_n = 1;
    idle_inputs();
    for (int k = 0; k < 8; k++) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
